// File: rtl/etcpu_mem_pkg.sv
// Shared types and constants for the etcpu main-memory arbiter and its clients.
package etcpu_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DAT_W  = 32;

    typedef enum logic {
        TAG_IF = 1'b0,
        TAG_MA = 1'b1
    } req_tag_e;

    typedef struct packed {
        logic     valid;
        req_tag_e tag;
    } lat_ent_t;

endpackage

// File: rtl/etcpu_mem_lat_pipe.sv
// Fixed-depth shift register carrying {valid, tag} alongside outstanding memory reads.
module etcpu_mem_lat_pipe
    import etcpu_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  lat_ent_t in_ent,
    output lat_ent_t out_ent
);

    lat_ent_t stage_q [DEPTH];
    lat_ent_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_ent;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_ent = stage_q[DEPTH-1];

endmodule

// File: rtl/etcpu_mem_arb.sv
// Single-port main memory arbiter between fetch (reads) and memory-access (loads/stores),
// with fetch starvation protection and tagged read-return routing.
module etcpu_mem_arb
    import etcpu_mem_pkg::*;
#(
    parameter int ADDR_W     = etcpu_mem_pkg::ADDR_W,
    parameter int DAT_W      = etcpu_mem_pkg::DAT_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DAT_W-1:0]  if_rdata,
    input  logic              ma_req,
    input  logic              ma_wen,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DAT_W-1:0]  ma_wdata,
    output logic              ma_gnt,
    output logic              ma_rvalid,
    output logic [DAT_W-1:0]  ma_rdata,
    output logic              mem_cs,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DAT_W-1:0]  mem_dat_in,
    input  logic [DAT_W-1:0]  mem_dat_out,
    output logic [2:0]        starve_cnt_o
);

    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       starved;
    lat_ent_t   push_ent, pop_ent;

    assign starved = (starve_cnt_q == 3'(STARVE_MAX));

    // Data side wins unless fetch has been denied STARVE_MAX cycles in a row.
    always_comb begin
        if_gnt = 1'b0;
        ma_gnt = 1'b0;
        if (if_req && (!ma_req || starved)) begin
            if_gnt = 1'b1;
        end else if (ma_req) begin
            ma_gnt = 1'b1;
        end
    end

    always_comb begin
        starve_cnt_d = 3'd0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        mem_cs     = if_gnt | ma_gnt;
        mem_wen    = ma_gnt & ma_wen;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ma_gnt) begin
            mem_addr   = ma_addr;
            mem_dat_in = ma_wdata;
        end
    end

    always_comb begin
        push_ent.valid = if_gnt | (ma_gnt & ~ma_wen);
        push_ent.tag   = if_gnt ? TAG_IF : TAG_MA;
    end

    etcpu_mem_lat_pipe #(
        .DEPTH (MEM_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_ent  (push_ent),
        .out_ent (pop_ent)
    );

    assign if_rvalid    = pop_ent.valid && (pop_ent.tag == TAG_IF);
    assign ma_rvalid    = pop_ent.valid && (pop_ent.tag == TAG_MA);
    assign if_rdata     = mem_dat_out;
    assign ma_rdata     = mem_dat_out;
    assign starve_cnt_o = starve_cnt_q;

endmodule
